// File: rtl/aether_bus_pkg.sv
// Shared definitions for the peripheral bus fabric: FSM encoding, error data, region map.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package aether_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } bus_state_t;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hBADB_AD00;

    // Region index = m_addr[31:28]
    localparam logic [3:0] REGION_RAM   = 4'd0;
    localparam logic [3:0] REGION_GPIO  = 4'd1;
    localparam logic [3:0] REGION_UART  = 4'd2;
    localparam logic [3:0] REGION_TIMER = 4'd3;
    localparam logic [3:0] REGION_SPI   = 4'd4;

    function automatic logic [3:0] region_of(input logic [31:0] addr);
        return addr[31:28];
    endfunction

endpackage

// File: rtl/periph_bus_fabric_if.sv
// Core-side and slave-side signal bundle of the peripheral bus fabric.
// Latency: n/a (wiring only).
// Backpressure: core holds m_wen/m_ren until m_done; slaves stall via s_wready/s_rvalid.
interface periph_bus_fabric_if #(
    parameter int NUM_SLAVES = 5
);
    // Core data port
    logic [31:0]              m_addr;
    logic [31:0]              m_wdata;
    logic [3:0]               m_wmask;
    logic                     m_wen;
    logic                     m_ren;
    logic [31:0]              m_rdata;
    logic                     m_done;
    logic                     m_err;
    // Shared slave bus plus per-slave strobes and handshakes
    logic [31:0]              s_addr;
    logic [31:0]              s_wdata;
    logic [3:0]               s_wstrb;
    logic [NUM_SLAVES-1:0]    s_wen;
    logic [NUM_SLAVES-1:0]    s_ren;
    logic [32*NUM_SLAVES-1:0] s_rdata;
    logic [NUM_SLAVES-1:0]    s_rvalid;
    logic [NUM_SLAVES-1:0]    s_wready;

    // Fabric view: it masters the slave bus and answers the core.
    modport master (
        input  m_addr, m_wdata, m_wmask, m_wen, m_ren,
        output m_rdata, m_done, m_err,
        output s_addr, s_wdata, s_wstrb, s_wen, s_ren,
        input  s_rdata, s_rvalid, s_wready
    );

    // Environment view: the core plus the attached peripherals.
    modport slave (
        output m_addr, m_wdata, m_wmask, m_wen, m_ren,
        input  m_rdata, m_done, m_err,
        input  s_addr, s_wdata, s_wstrb, s_wen, s_ren,
        output s_rdata, s_rvalid, s_wready
    );

endinterface

// File: rtl/bus_timeout_ctr.sv
// Counts ACCESS cycles and flags expiry on the TIMEOUT-th cycle without a handshake.
// Latency: expired is combinational from the count, asserted during the TIMEOUT-th enabled cycle.
// Backpressure: none; clear has priority over enable.
module bus_timeout_ctr #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

    logic [15:0] cnt;

    // Count enabled cycles since the last clear, holding at all-ones.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && cnt != 16'hFFFF) begin
            cnt <= cnt + 16'd1;
        end
    end

    // cnt holds the number of completed ACCESS cycles, so TIMEOUT-1 marks the last allowed one.
    assign expired = enable && (cnt >= LIMIT);

endmodule

// File: rtl/periph_bus_fabric.sv
// Decodes core requests to one-hot slave strobes and returns one registered completion (optional timeout: BUS_TIMEOUT_EN).
// Latency: 2 cycles minimum (+1 per slave wait cycle); decode error completes in 1 cycle.
// Backpressure: strobe held until the selected slave's s_wready/s_rvalid; core must hold its request until m_done.
module periph_bus_fabric
    import aether_bus_pkg::*;
#(
    parameter int          NUM_SLAVES = 5,
    parameter int          TIMEOUT    = 255,
    parameter logic [31:0] ERR_DATA   = ERR_DATA_DEFAULT
) (
    input  logic                clk,
    input  logic                rstn,
    periph_bus_fabric_if.master bus,
    output logic [31:0]         err_addr,
    output logic [7:0]          err_count
);

    bus_state_t state, state_nxt;

    logic [31:0]           lat_addr;
    logic [31:0]           lat_wdata;
    logic [3:0]            lat_wmask;
    logic                  lat_write;
    logic [3:0]            lat_idx;

    logic                  req;
    logic [3:0]            req_idx;
    logic                  req_idx_ok;
    logic [NUM_SLAVES-1:0] req_onehot;
    logic [15:0]           rvalid_pad;
    logic [15:0]           wready_pad;
    logic                  hs_sel;
    logic [31:0]           rdata_sel;
    logic                  in_access;
    logic                  tmo_expired;

    logic                  go_access;
    logic                  go_dec_err;
    logic                  go_done;
    logic                  go_tmo;

    assign req        = bus.m_wen | bus.m_ren;
    assign req_idx    = region_of(bus.m_addr);
    assign req_idx_ok = int'(req_idx) < NUM_SLAVES;
    assign req_onehot = NUM_SLAVES'(1) << req_idx;
    assign in_access  = (state == ACCESS);

    // Padding to 16 lets the 4-bit latched index select a handshake bit for any NUM_SLAVES.
    assign rvalid_pad = 16'(bus.s_rvalid);
    assign wready_pad = 16'(bus.s_wready);
    assign hs_sel     = lat_write ? wready_pad[lat_idx] : rvalid_pad[lat_idx];

    // Read-data mux for the latched slave index.
    always_comb begin
        rdata_sel = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (lat_idx == 4'(i)) begin
                rdata_sel = bus.s_rdata[32*i +: 32];
            end
        end
    end

`ifdef BUS_TIMEOUT_EN
    bus_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rstn    (rstn),
        .clear   (go_access),
        .enable  (in_access),
        .expired (tmo_expired)
    );
`else
    logic unused_tmo;
    assign unused_tmo  = (TIMEOUT > 0);
    assign tmo_expired = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and one-cycle transition events; a handshake beats a same-cycle timeout.
    always_comb begin
        state_nxt  = state;
        go_access  = 1'b0;
        go_dec_err = 1'b0;
        go_done    = 1'b0;
        go_tmo     = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (req_idx_ok) begin
                        state_nxt = ACCESS;
                        go_access = 1'b1;
                    end else begin
                        state_nxt  = RESP;
                        go_dec_err = 1'b1;
                    end
                end
            end
            ACCESS: begin
                if (hs_sel) begin
                    state_nxt = RESP;
                    go_done   = 1'b1;
                end else if (tmo_expired) begin
                    state_nxt = RESP;
                    go_tmo    = 1'b1;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Capture the request in IDLE; write wins when both enables are high.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_wmask <= '0;
            lat_write <= 1'b0;
            lat_idx   <= '0;
        end else if (state == IDLE && req) begin
            lat_addr  <= bus.m_addr;
            lat_wdata <= bus.m_wdata;
            lat_wmask <= bus.m_wmask;
            lat_write <= bus.m_wen;
            lat_idx   <= req_idx;
        end
    end

    assign bus.s_addr  = {4'h0, lat_addr[27:0]};
    assign bus.s_wdata = lat_wdata;
    assign bus.s_wstrb = lat_wmask;

    // Slave strobes: level from ACCESS entry until handshake or timeout.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus.s_wen <= '0;
            bus.s_ren <= '0;
        end else if (go_access) begin
            bus.s_wen <= bus.m_wen ? req_onehot : '0;
            bus.s_ren <= bus.m_wen ? '0 : req_onehot;
        end else if (go_done || go_tmo) begin
            bus.s_wen <= '0;
            bus.s_ren <= '0;
        end
    end

    // Registered completion to the core, valid for the single RESP cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus.m_done  <= 1'b0;
            bus.m_err   <= 1'b0;
            bus.m_rdata <= '0;
        end else begin
            bus.m_done <= go_dec_err | go_done | go_tmo;
            bus.m_err  <= go_dec_err | go_tmo;
            if (go_done) begin
                bus.m_rdata <= lat_write ? 32'h0 : rdata_sel;
            end else if (go_dec_err || go_tmo) begin
                bus.m_rdata <= ERR_DATA;
            end
        end
    end

    // Error log: address of the latest failed access and a saturating count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_addr  <= '0;
            err_count <= '0;
        end else if (go_dec_err || go_tmo) begin
            err_addr  <= go_dec_err ? bus.m_addr : lat_addr;
            err_count <= (err_count == 8'hFF) ? err_count : err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_periph_bus_fabric.sv
// Self-checking bench for periph_bus_fabric with a scoreboard of expected completions.
// Latency: measured from request drive to m_done in whole cycles.
// Backpressure: behavioural slaves stall for a programmable number of wait cycles or stay silent.
module tb_periph_bus_fabric;
    import aether_bus_pkg::*;

    localparam int NS = 5;
    localparam logic [31:0] ERRD = 32'hBADB_AD00;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [7:0]  lat;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic [31:0] err_addr;
    logic [7:0]  err_count;

    periph_bus_fabric_if #(.NUM_SLAVES(NS)) bus ();

    periph_bus_fabric #(
        .NUM_SLAVES (NS),
        .TIMEOUT    (8),
        .ERR_DATA   (ERRD)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .bus       (bus),
        .err_addr  (err_addr),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];
    int exp_err_count = 0;

    // Slave model configuration
    logic [31:0] slave_data [NS];
    int          resp_wait   = 0;
    bit          resp_silent = 1'b0;
    logic [NS-1:0] noise_r = '0;
    logic [NS-1:0] noise_w = '0;

    // Slave model observations
    int run_k = 0;
    int run_len = 0;
    int total_active = 0;
    logic [NS-1:0] wen_any = '0;
    logic [NS-1:0] ren_any = '0;
    logic [NS-1:0] first_en = '0;
    bit changed = 1'b0;
    logic [31:0] saddr_seen = '0;
    logic [31:0] swdata_seen = '0;
    logic [3:0]  swstrb_seen = '0;

    assign bus.s_rdata = {slave_data[4], slave_data[3], slave_data[2], slave_data[1], slave_data[0]};

    // Behavioural slaves: answer the strobed slave after resp_wait cycles, with optional noise elsewhere.
    always @(negedge clk) begin
        logic [NS-1:0] hs;
        if (bus.s_wen != '0 || bus.s_ren != '0) begin
            if (run_k == 0) begin
                wen_any     = '0;
                ren_any     = '0;
                changed     = 1'b0;
                first_en    = bus.s_wen | bus.s_ren;
                saddr_seen  = bus.s_addr;
                swdata_seen = bus.s_wdata;
                swstrb_seen = bus.s_wstrb;
            end else if ((bus.s_wen | bus.s_ren) != first_en) begin
                changed = 1'b1;
            end
            run_k++;
            run_len = run_k;
            total_active++;
            wen_any |= bus.s_wen;
            ren_any |= bus.s_ren;
            hs = (!resp_silent && (run_k - 1) >= resp_wait) ? (bus.s_wen | bus.s_ren) : '0;
            bus.s_wready = (bus.s_wen & hs) | noise_w;
            bus.s_rvalid = (bus.s_ren & hs) | noise_r;
        end else begin
            run_k = 0;
            bus.s_wready = noise_w;
            bus.s_rvalid = noise_r;
        end
    end

    // Drive one core request, hold it until m_done (bounded), then drop it.
    task automatic do_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                          input logic w, input logic r,
                          output bit got, output int lat, output logic [31:0] rd, output logic e);
        @(negedge clk);
        bus.m_addr  = a;
        bus.m_wdata = d;
        bus.m_wmask = m;
        bus.m_wen   = w;
        bus.m_ren   = r;
        got = 1'b0;
        lat = 0;
        rd  = '0;
        e   = 1'b0;
        for (int c = 1; c <= 60 && !got; c++) begin
            @(negedge clk);
            if (bus.m_done === 1'b1) begin
                got = 1'b1;
                lat = c;
                rd  = bus.m_rdata;
                e   = bus.m_err;
            end
        end
        bus.m_wen = 1'b0;
        bus.m_ren = 1'b0;
    endtask

    task automatic test_reset();
        bus.m_addr = '0; bus.m_wdata = '0; bus.m_wmask = '0; bus.m_wen = 1'b0; bus.m_ren = 1'b0;
        for (int i = 0; i < NS; i++) slave_data[i] = '0;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if ({bus.m_done, bus.m_err, bus.m_rdata} !== 34'h0) begin errors++;
            $display("FAIL reset_m got %b/%b/%h exp 0", bus.m_done, bus.m_err, bus.m_rdata); end
        checks++; if ({bus.s_wen, bus.s_ren} !== '0) begin errors++;
            $display("FAIL reset_strobes got %b/%b exp 0", bus.s_wen, bus.s_ren); end
        checks++; if ({bus.s_addr, bus.s_wdata, bus.s_wstrb} !== 68'h0) begin errors++;
            $display("FAIL reset_sbus got %h/%h/%h exp 0", bus.s_addr, bus.s_wdata, bus.s_wstrb); end
        checks++; if ({err_addr, err_count} !== 40'h0) begin errors++;
            $display("FAIL reset_err got %h/%0d exp 0", err_addr, err_count); end
        rstn = 1'b1;
        exp_err_count = 0;
    endtask

    task automatic test_read();
        bit got; int lat; logic [31:0] rd; logic e; exp_t x;
        slave_data[REGION_GPIO] = 32'h0000_00A5;
        resp_wait = 0; resp_silent = 1'b0; noise_r = '0; noise_w = '0;
        exp_q.push_back('{rdata: 32'h0000_00A5, err: 1'b0, lat: 8'd2});
        do_txn(32'h1000_0004, 32'h0, 4'h0, 1'b0, 1'b1, got, lat, rd, e);
        x = exp_q.pop_front();
        checks++; if (!got) begin errors++; $display("FAIL read_done got none exp m_done"); end
        checks++; if (lat !== int'(x.lat)) begin errors++; $display("FAIL read_lat got %0d exp %0d", lat, x.lat); end
        checks++; if ({rd, e} !== {x.rdata, x.err}) begin errors++;
            $display("FAIL read_resp got %h/%b exp %h/%b", rd, e, x.rdata, x.err); end
        checks++; if (saddr_seen !== 32'h0000_0004) begin errors++;
            $display("FAIL read_saddr got %h exp 00000004", saddr_seen); end
        checks++; if ({ren_any, wen_any} !== {5'b00010, 5'b00000} || run_len != 1) begin errors++;
            $display("FAIL read_strobe got ren %b wen %b len %0d exp 00010 00000 1", ren_any, wen_any, run_len); end
    endtask

    task automatic test_write();
        bit got; int lat; logic [31:0] rd; logic e; exp_t x;
        resp_wait = 3; resp_silent = 1'b0; noise_w = 5'b11011; noise_r = 5'b11011;
        exp_q.push_back('{rdata: 32'h0, err: 1'b0, lat: 8'd5});
        do_txn(32'h2000_0000, 32'h0000_0055, 4'b0001, 1'b1, 1'b0, got, lat, rd, e);
        noise_w = '0; noise_r = '0;
        x = exp_q.pop_front();
        checks++; if (!got || lat !== int'(x.lat)) begin errors++;
            $display("FAIL write_lat got %0d (done %0b) exp %0d", lat, got, x.lat); end
        checks++; if ({rd, e} !== {x.rdata, x.err}) begin errors++;
            $display("FAIL write_resp got %h/%b exp %h/%b", rd, e, x.rdata, x.err); end
        checks++; if (wen_any !== 5'b00100 || ren_any !== 5'b0 || run_len != 4 || changed) begin errors++;
            $display("FAIL write_strobe got wen %b ren %b len %0d chg %0b exp 00100 00000 4 0", wen_any, ren_any, run_len, changed); end
        checks++; if ({swstrb_seen, swdata_seen, saddr_seen} !== {4'b0001, 32'h55, 32'h0}) begin errors++;
            $display("FAIL write_sbus got %b/%h/%h exp 0001/00000055/00000000", swstrb_seen, swdata_seen, saddr_seen); end
    endtask

    task automatic test_decode_err();
        bit got; int lat; logic [31:0] rd; logic e; exp_t x; int act0;
        act0 = total_active;
        exp_err_count++;
        exp_q.push_back('{rdata: ERRD, err: 1'b1, lat: 8'd1});
        do_txn(32'h7000_0000, 32'h0, 4'h0, 1'b0, 1'b1, got, lat, rd, e);
        x = exp_q.pop_front();
        checks++; if (!got || lat !== int'(x.lat)) begin errors++;
            $display("FAIL decerr_lat got %0d (done %0b) exp %0d", lat, got, x.lat); end
        checks++; if ({rd, e} !== {x.rdata, x.err}) begin errors++;
            $display("FAIL decerr_resp got %h/%b exp %h/%b", rd, e, x.rdata, x.err); end
        checks++; if (err_addr !== 32'h7000_0000 || int'(err_count) != exp_err_count) begin errors++;
            $display("FAIL decerr_log got %h/%0d exp 70000000/%0d", err_addr, err_count, exp_err_count); end
        checks++; if (total_active != act0) begin errors++;
            $display("FAIL decerr_nostrobe got %0d strobe cycles exp 0", total_active - act0); end
        exp_err_count++;
        exp_q.push_back('{rdata: ERRD, err: 1'b1, lat: 8'd1});
        do_txn(32'hF000_0010, 32'h1234_5678, 4'hF, 1'b1, 1'b0, got, lat, rd, e);
        x = exp_q.pop_front();
        checks++; if ({rd, e} !== {x.rdata, x.err} || lat !== int'(x.lat)) begin errors++;
            $display("FAIL decerr_wr got %h/%b lat %0d exp %h/%b lat %0d", rd, e, lat, x.rdata, x.err, x.lat); end
        checks++; if (err_addr !== 32'hF000_0010 || int'(err_count) != exp_err_count) begin errors++;
            $display("FAIL decerr_wr_log got %h/%0d exp f0000010/%0d", err_addr, err_count, exp_err_count); end
    endtask

    task automatic test_both_enables();
        bit got; int lat; logic [31:0] rd; logic e; exp_t x;
        slave_data[REGION_RAM] = 32'hDEAD_0001;
        resp_wait = 1; resp_silent = 1'b0;
        exp_q.push_back('{rdata: 32'h0, err: 1'b0, lat: 8'd3});
        do_txn(32'h0000_0100, 32'hCAFE_F00D, 4'b1111, 1'b1, 1'b1, got, lat, rd, e);
        x = exp_q.pop_front();
        checks++; if (wen_any !== 5'b00001 || ren_any !== 5'b00000) begin errors++;
            $display("FAIL both_strobe got wen %b ren %b exp 00001 00000", wen_any, ren_any); end
        checks++; if ({rd, e} !== {x.rdata, x.err} || lat !== int'(x.lat)) begin errors++;
            $display("FAIL both_resp got %h/%b lat %0d exp %h/%b lat %0d", rd, e, lat, x.rdata, x.err, x.lat); end
    endtask

    task automatic test_back_to_back();
        bit got; int lat; logic [31:0] rd; logic e; exp_t x;
        for (int i = 0; i < 10; i++) begin
            logic [3:0] sidx;
            logic wr;
            sidx = 4'(i % NS);
            wr = (i % 3 == 1);
            slave_data[sidx] = $urandom;
            resp_wait = $urandom_range(0, 2);
            resp_silent = 1'b0;
            exp_q.push_back('{rdata: wr ? 32'h0 : slave_data[sidx], err: 1'b0, lat: 8'(2 + resp_wait)});
            do_txn({sidx, 28'(i * 16)}, 32'(i), 4'hF, wr, !wr, got, lat, rd, e);
            x = exp_q.pop_front();
            checks++; if (!got || {rd, e} !== {x.rdata, x.err} || lat !== int'(x.lat)) begin errors++;
                $display("FAIL b2b_%0d got %h/%b lat %0d exp %h/%b lat %0d", i, rd, e, lat, x.rdata, x.err, x.lat); end
            @(negedge clk);
            checks++; if (bus.m_done !== 1'b0) begin errors++;
                $display("FAIL b2b_pulse_%0d got m_done %b exp 0", i, bus.m_done); end
        end
    endtask

`ifdef BUS_TIMEOUT_EN
    task automatic test_timeout();
        bit got; int lat; logic [31:0] rd; logic e; exp_t x;
        resp_silent = 1'b1;
        exp_err_count++;
        exp_q.push_back('{rdata: ERRD, err: 1'b1, lat: 8'd9});
        do_txn(32'h3000_0040, 32'h0, 4'h0, 1'b0, 1'b1, got, lat, rd, e);
        x = exp_q.pop_front();
        checks++; if (run_len != 8 || ren_any !== 5'b01000) begin errors++;
            $display("FAIL tmo_strobe got len %0d ren %b exp 8 01000", run_len, ren_any); end
        checks++; if (!got || {rd, e} !== {x.rdata, x.err} || lat !== int'(x.lat)) begin errors++;
            $display("FAIL tmo_resp got %h/%b lat %0d exp %h/%b lat %0d", rd, e, lat, x.rdata, x.err, x.lat); end
        checks++; if (err_addr !== 32'h3000_0040 || int'(err_count) != exp_err_count) begin errors++;
            $display("FAIL tmo_log got %h/%0d exp 30000040/%0d", err_addr, err_count, exp_err_count); end
        resp_silent = 1'b0;
        resp_wait = 7;
        slave_data[REGION_TIMER] = 32'h00C0_FFEE;
        exp_q.push_back('{rdata: 32'h00C0_FFEE, err: 1'b0, lat: 8'd9});
        do_txn(32'h3000_0000, 32'h0, 4'h0, 1'b0, 1'b1, got, lat, rd, e);
        x = exp_q.pop_front();
        checks++; if (!got || {rd, e} !== {x.rdata, x.err} || lat !== int'(x.lat) || run_len != 8) begin errors++;
            $display("FAIL tmo_race got %h/%b lat %0d len %0d exp %h/%b lat %0d len 8", rd, e, lat, run_len, x.rdata, x.err, x.lat); end
    endtask
`endif

    task automatic test_reset_mid();
        bit got; int lat; logic [31:0] rd; logic e; exp_t x;
        resp_silent = 1'b1;
        @(negedge clk);
        bus.m_addr = 32'h4000_0008; bus.m_wen = 1'b0; bus.m_ren = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.s_ren !== 5'b10000) begin errors++;
            $display("FAIL midrst_pre got s_ren %b exp 10000", bus.s_ren); end
        #2 rstn = 1'b0;
        #1;
        exp_err_count = 0;
        checks++; if ({bus.s_wen, bus.s_ren} !== '0 || bus.s_addr !== 32'h0) begin errors++;
            $display("FAIL midrst_strobe got %b/%b addr %h exp 0", bus.s_wen, bus.s_ren, bus.s_addr); end
        checks++; if ({bus.m_done, bus.m_err, bus.m_rdata} !== 34'h0 || {err_addr, err_count} !== 40'h0) begin errors++;
            $display("FAIL midrst_out got %b/%b/%h %h/%0d exp 0", bus.m_done, bus.m_err, bus.m_rdata, err_addr, err_count); end
        bus.m_ren = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        resp_silent = 1'b0;
        resp_wait = 0;
        slave_data[REGION_SPI] = 32'h0000_0044;
        exp_q.push_back('{rdata: 32'h0000_0044, err: 1'b0, lat: 8'd2});
        do_txn(32'h4000_0008, 32'h0, 4'h0, 1'b0, 1'b1, got, lat, rd, e);
        x = exp_q.pop_front();
        checks++; if (!got || {rd, e} !== {x.rdata, x.err} || lat !== int'(x.lat)) begin errors++;
            $display("FAIL midrst_after got %h/%b lat %0d exp %h/%b lat %0d", rd, e, lat, x.rdata, x.err, x.lat); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_decode_err();
        test_both_enables();
        test_back_to_back();
`ifdef BUS_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/periph_bus_fabric.md
# periph_bus_fabric

Parametrised peripheral bus fabric between the RV32 core data port and N memory-mapped slaves (RAM, GPIO, UART, timer, SPI, …). It decodes the top address nibble into a one-hot slave select and holds each request until the slave's `wready`/`rvalid` handshake. It returns a single registered completion to the core, plus an error response for unmapped regions or unresponsive slaves. It supersedes the combinational device-select/read-mux path.

## Interface
- `NUM_SLAVES`, 5: number of slave ports, 1..16; slave i owns address region `m_addr[31:28] == i`.
- `TIMEOUT`, 255: max ACCESS cycles before a bus error, 1..65535.
- `ERR_DATA`, 32'hBADB_AD00: read data returned on any error.
- `clk` in 1: clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `m_addr` in 32: core address.
- `m_wdata` in 32: core write data.
- `m_wmask` in 4: byte write mask.
- `m_wen` in 1: write request (level).
- `m_ren` in 1: read request (level).
- `m_rdata` out 32: registered read data, valid with `m_done`.
- `m_done` out 1: one-cycle completion pulse.
- `m_err` out 1: error qualifier, valid with `m_done`.
- `s_addr` out 32: `{4'h0, latched addr[27:0]}`, shared by all slaves.
- `s_wdata` out 32: latched write data, shared.
- `s_wstrb` out 4: latched mask, shared.
- `s_wen` out NUM_SLAVES: one-hot write enable.
- `s_ren` out NUM_SLAVES: one-hot read enable.
- `s_rdata` in 32*NUM_SLAVES: slave i read data at bits [32i+31:32i].
- `s_rvalid` in NUM_SLAVES: per-slave read valid.
- `s_wready` in NUM_SLAVES: per-slave write accept.
- `err_addr` out 32: address of the most recent errored transaction.
- `err_count` out 8: saturating error counter.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - If `m_wen | m_ren`: latch address, data, mask, direction and slave index.
  - Write wins if both are asserted; the read is dropped, not queued.
  - Index ≥ NUM_SLAVES → RESP with error (decode error). Otherwise → ACCESS.
- **ACCESS**
  - Assert the selected `s_wen` or `s_ren` bit as a level, held constant.
  - Complete on `s_wready[i]` for a write or `s_rvalid[i]` for a read.
  - Completion registers `m_rdata` (reads: `s_rdata` slice i; writes: 0) and goes to RESP.
  - Only the selected slave's handshake is observed; other slaves' handshakes are ignored.
- **RESP**
  - `m_done` = 1 for exactly one cycle, then IDLE.
  - Error completion: `m_err` = 1, `m_rdata` = ERR_DATA (reads and writes alike), `err_addr` updated, `err_count` += 1, saturating at 255.
- **Core rule:** the core holds its request until `m_done`. A request present in the IDLE cycle after RESP is a new transaction.
- **Reset mid-transaction:** all state clears and any in-flight access is abandoned. Slaves see `s_wen`/`s_ren` drop asynchronously.

## Timing
- Reset values:
  - `m_rdata` = 0, `m_done` = 0, `m_err` = 0.
  - `s_wen` = 0, `s_ren` = 0, `s_addr` = 0, `s_wdata` = 0, `s_wstrb` = 0.
  - `err_addr` = 0, `err_count` = 0. FSM = IDLE.
- Request sampled at edge 0. `s_*en` is high from edge 1. A slave responding in the same cycle gives `m_done` high after edge 2 (minimum latency 2 cycles).
- Each slave wait cycle adds one cycle of latency.
- Decode error: `m_done` + `m_err` after edge 1, with no slave strobe at all.
- All `m_*` outputs are registered; there is no combinational path from `s_*` to `m_*`.

## Configuration
- `BUS_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entry to ACCESS and increments each ACCESS cycle.
  - When the count reaches TIMEOUT with no handshake: drop `s_*en`, go to RESP with error.
  - A handshake arriving in the same cycle as the timeout takes priority and completes normally.
- Undefined: no counter; ACCESS waits indefinitely. Decode errors still respond.

## Structure
- Package `aether_bus_pkg`: FSM state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2), `ERR_DATA` default, region index constants (RAM=0, GPIO=1, UART=2, TIMER=3, SPI=4).
- Sub-module `bus_timeout_ctr` (clear, enable, `TIMEOUT` compare → `expired`), instantiated only under `BUS_TIMEOUT_EN`.

## Test plan
- Read 0x1000_0004 with slave 1 giving `s_rvalid` in the same cycle, `s_rdata` slice = 32'h0000_00A5 → `m_done` at cycle 2, `m_rdata` = 0x0000_00A5, `m_err` = 0, `s_addr` = 0x0000_0004.
- Write 0x2000_0000, data 0x55, mask 4'b0001, slave 2 `wready` after 3 wait cycles → `s_wen` = 5'b00100 held for 4 cycles, `m_done` at cycle 5, `s_wstrb` = 4'b0001.
- Read 0x7000_0000 with NUM_SLAVES = 5 → `m_done` + `m_err` at cycle 1, `m_rdata` = 0xBADB_AD00, `err_addr` = 0x7000_0000, `err_count` = 1, no `s_ren` bit set.
- `BUS_TIMEOUT_EN`, TIMEOUT = 8, slave 3 silent → `s_ren[3]` high for 8 cycles, then `m_err` = 1 with ERR_DATA. Repeat with `s_rvalid` arriving on cycle 8 → normal completion, no error.
- Assert `m_wen` and `m_ren` together to slave 0 → only `s_wen[0]` asserts, `s_ren` stays 0.
- Deassert `rstn` during ACCESS → `s_*en` drops immediately, all outputs at reset values. The next request after reset completes normally.
